// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, state encoding and small helpers for the
// memory-stage engine (mem_access_unit and mem_load_align).
package mem_pkg;

  // Access size encodings carried on EX_MEM_LS_bit (2'b11 behaves as word).
  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  // Half accesses need addr[0] clear; word (and 2'b11) need addr[1:0] clear.
  // Byte accesses are always aligned.
  function automatic logic is_misaligned(input logic [1:0] ls_bit,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (ls_bit)
      LS_BYTE: mis = 1'b0;
      LS_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load-data aligner.
// Ports:
//   rdata_i   32  raw word returned by memory
//   addr_lo_i  2  byte offset of the access
//   ls_bit_i   2  access size (word/half/byte, 11 = word)
//   ext_op_i   1  1 sign-extend, 0 zero-extend
//   load_o    32  aligned, extended load value
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  ls_bit_i,
  input  logic        ext_op_i,
  output logic [31:0] load_o
);

  logic [31:0] sh;

  assign sh = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    load_o = rdata_i;
    case (ls_bit_i)
      LS_BYTE: load_o = {{24{ext_op_i & sh[7]}}, sh[7:0]};
      LS_HALF: load_o = {{16{ext_op_i & sh[15]}}, sh[15:0]};
      default: load_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage engine between the EX/MEM and MEM/WB
// pipeline registers. Issues one handshaked data-memory access per
// load/store, stalls upstream while it is outstanding, traps misaligned
// accesses, and writes the retiring instruction into MEM/WB.
// Ports:
//   clock, reset          sole clock, synchronous active-high reset
//   EX_MEM_*              instruction presented by the EX/MEM register
//   mem_req/we/addr/be/wdata  registered memory request (stable while BUSY)
//   mem_ready, mem_rdata  memory completion and read data
//   mem_stall             combinational freeze of PC .. EX/MEM
//   misalign              one-cycle pulse when an access is trapped
//   MEM_WB_*              registered MEM/WB pipeline register
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  EX_MEM_LS_bit,
  input  logic        EX_MEM_MemtoReg,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_RegWrite,
  input  logic        EX_MEM_Ext_op,
  input  logic [63:0] EX_MEM_prod,
  input  logic [31:0] EX_MEM_mux5_out,
  input  logic [31:0] EX_MEM_mux3_out,
  input  logic [5:0]  EX_MEM_mux1_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        misalign,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_MemtoReg,
  output logic [63:0] MEM_WB_prod,
  output logic [31:0] MEM_WB_alu,
  output logic [31:0] MEM_WB_load,
  output logic [5:0]  MEM_WB_dst
);

  mem_state_e  state_q;

  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        misalign_q;

  // Latched copy of the instruction while its access is outstanding.
  logic [1:0]  lat_addr_lo_q, lat_ls_q;
  logic        lat_ext_q, lat_load_q, lat_regwrite_q;
  logic [63:0] lat_prod_q;
  logic [31:0] lat_alu_q;
  logic [5:0]  lat_dst_q;

  logic        wb_regwrite_q, wb_memtoreg_q;
  logic [63:0] wb_prod_q;
  logic [31:0] wb_alu_q, wb_load_q;
  logic [5:0]  wb_dst_q;

  logic        need, misal, issue;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_val;

  assign need  = EX_MEM_MemtoReg | EX_MEM_MemWrite;
  assign misal = is_misaligned(EX_MEM_LS_bit, EX_MEM_mux5_out[1:0]);
  assign issue = need & ~misal;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = EX_MEM_mux3_out;
    case (EX_MEM_LS_bit)
      LS_BYTE: begin
        be_d    = 4'b0001 << EX_MEM_mux5_out[1:0];
        wdata_d = {4{EX_MEM_mux3_out[7:0]}};
      end
      LS_HALF: begin
        be_d    = EX_MEM_mux5_out[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{EX_MEM_mux3_out[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = EX_MEM_mux3_out;
      end
    endcase
  end

  mem_load_align u_align (
    .rdata_i   (mem_rdata),
    .addr_lo_i (lat_addr_lo_q),
    .ls_bit_i  (lat_ls_q),
    .ext_op_i  (lat_ext_q),
    .load_o    (load_val)
  );

  // Stall covers the issuing IDLE cycle and every BUSY cycle without ready;
  // the completing cycle releases the pipeline so EX/MEM advances with it.
  always_comb begin
    mem_stall = 1'b0;
    if (!reset) begin
      if (state_q == IDLE) mem_stall = issue;
      else                 mem_stall = ~mem_ready;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      misalign_q     <= 1'b0;
      lat_addr_lo_q  <= '0;
      lat_ls_q       <= '0;
      lat_ext_q      <= 1'b0;
      lat_load_q     <= 1'b0;
      lat_regwrite_q <= 1'b0;
      lat_prod_q     <= '0;
      lat_alu_q      <= '0;
      lat_dst_q      <= '0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_prod_q      <= '0;
      wb_alu_q       <= '0;
      wb_load_q      <= '0;
      wb_dst_q       <= '0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue) begin
            lat_addr_lo_q  <= EX_MEM_mux5_out[1:0];
            lat_ls_q       <= EX_MEM_LS_bit;
            lat_ext_q      <= EX_MEM_Ext_op;
            lat_load_q     <= EX_MEM_MemtoReg & ~EX_MEM_MemWrite;
            lat_regwrite_q <= EX_MEM_RegWrite;
            lat_prod_q     <= EX_MEM_prod;
            lat_alu_q      <= EX_MEM_mux5_out;
            lat_dst_q      <= EX_MEM_mux1_out;
            req_q          <= 1'b1;
            we_q           <= EX_MEM_MemWrite;
            addr_q         <= {EX_MEM_mux5_out[31:2], 2'b00};
            be_q           <= EX_MEM_MemWrite ? be_d : 4'b0000;
            wdata_q        <= EX_MEM_MemWrite ? wdata_d : 32'h0;
            wb_regwrite_q  <= 1'b0;
            wb_memtoreg_q  <= 1'b0;
            wb_prod_q      <= '0;
            wb_alu_q       <= '0;
            wb_load_q      <= '0;
            wb_dst_q       <= '0;
            state_q        <= BUSY;
          end else begin
            // Plain pass-through, or a trapped access retiring with no
            // architectural effect (need is only set here when misaligned).
            wb_regwrite_q <= EX_MEM_RegWrite & ~need;
            wb_memtoreg_q <= 1'b0;
            wb_prod_q     <= EX_MEM_prod;
            wb_alu_q      <= EX_MEM_mux5_out;
            wb_load_q     <= '0;
            wb_dst_q      <= EX_MEM_mux1_out;
            misalign_q    <= need;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            wb_regwrite_q <= lat_regwrite_q;
            wb_memtoreg_q <= lat_load_q;
            wb_prod_q     <= lat_prod_q;
            wb_alu_q      <= lat_alu_q;
            wb_load_q     <= lat_load_q ? load_val : 32'h0;
            wb_dst_q      <= lat_dst_q;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            state_q       <= IDLE;
          end else begin
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_prod_q     <= '0;
            wb_alu_q      <= '0;
            wb_load_q     <= '0;
            wb_dst_q      <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req         = req_q;
  assign mem_we          = we_q;
  assign mem_addr        = addr_q;
  assign mem_be          = be_q;
  assign mem_wdata       = wdata_q;
  assign misalign        = misalign_q;
  assign MEM_WB_RegWrite = wb_regwrite_q;
  assign MEM_WB_MemtoReg = wb_memtoreg_q;
  assign MEM_WB_prod     = wb_prod_q;
  assign MEM_WB_alu      = wb_alu_q;
  assign MEM_WB_load     = wb_load_q;
  assign MEM_WB_dst      = wb_dst_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  EX_MEM_LS_bit;
  logic        EX_MEM_MemtoReg, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_Ext_op;
  logic [63:0] EX_MEM_prod;
  logic [31:0] EX_MEM_mux5_out, EX_MEM_mux3_out;
  logic [5:0]  EX_MEM_mux1_out;
  logic        mem_req, mem_we, mem_ready, mem_stall, misalign;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        MEM_WB_RegWrite, MEM_WB_MemtoReg;
  logic [63:0] MEM_WB_prod;
  logic [31:0] MEM_WB_alu, MEM_WB_load;
  logic [5:0]  MEM_WB_dst;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  mem_access_unit dut (
    .clock(clock), .reset(reset),
    .EX_MEM_LS_bit(EX_MEM_LS_bit), .EX_MEM_MemtoReg(EX_MEM_MemtoReg),
    .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .EX_MEM_Ext_op(EX_MEM_Ext_op), .EX_MEM_prod(EX_MEM_prod),
    .EX_MEM_mux5_out(EX_MEM_mux5_out), .EX_MEM_mux3_out(EX_MEM_mux3_out),
    .EX_MEM_mux1_out(EX_MEM_mux1_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_stall(mem_stall), .misalign(misalign),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_MemtoReg(MEM_WB_MemtoReg),
    .MEM_WB_prod(MEM_WB_prod), .MEM_WB_alu(MEM_WB_alu),
    .MEM_WB_load(MEM_WB_load), .MEM_WB_dst(MEM_WB_dst)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_nop();
    EX_MEM_LS_bit   = 2'b00;
    EX_MEM_MemtoReg = 1'b0;
    EX_MEM_MemWrite = 1'b0;
    EX_MEM_RegWrite = 1'b0;
    EX_MEM_Ext_op   = 1'b0;
    EX_MEM_prod     = 64'h0;
    EX_MEM_mux5_out = 32'h0;
    EX_MEM_mux3_out = 32'h0;
    EX_MEM_mux1_out = 6'd0;
    mem_ready       = 1'b0;
    mem_rdata       = 32'h0;
  endtask

  task automatic test_reset();
    drive_nop();
    reset = 1'b1;
    tick();
    tick();
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", mem_req); end
    tests++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin fails++; $display("FAIL reset_mem_port: got we=%b be=%b addr=%h wdata=%h want 0", mem_we, mem_be, mem_addr, mem_wdata); end
    tests++; if (mem_stall !== 1'b0 || misalign !== 1'b0) begin fails++; $display("FAIL reset_stall_misalign: got %b %b want 0 0", mem_stall, misalign); end
    tests++; if ({MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_prod, MEM_WB_alu, MEM_WB_load, MEM_WB_dst} !== '0) begin fails++; $display("FAIL reset_mem_wb: got nonzero MEM_WB alu=%h dst=%0d", MEM_WB_alu, MEM_WB_dst); end
    reset = 1'b0;
  endtask

  task automatic test_alu_pass();
    drive_nop();
    EX_MEM_RegWrite = 1'b1;
    EX_MEM_mux5_out = 32'h0000_1234;
    EX_MEM_mux1_out = 6'd5;
    EX_MEM_prod     = 64'hDEAD_BEEF_0123_4567;
    mem_ready       = 1'b1;   // ready in IDLE must be ignored
    #1;
    tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL alu_stall: got %b want 0", mem_stall); end
    tick();
    tests++; if (MEM_WB_alu !== 32'h1234 || MEM_WB_dst !== 6'd5 || MEM_WB_RegWrite !== 1'b1 || MEM_WB_MemtoReg !== 1'b0) begin
      fails++; $display("FAIL alu_wb: got alu=%h dst=%0d rw=%b m2r=%b want 1234 5 1 0", MEM_WB_alu, MEM_WB_dst, MEM_WB_RegWrite, MEM_WB_MemtoReg); end
    tests++; if (MEM_WB_prod !== 64'hDEAD_BEEF_0123_4567) begin fails++; $display("FAIL alu_prod: got %h want deadbeef01234567", MEM_WB_prod); end
    tests++; if (mem_req !== 1'b0 || mem_stall !== 1'b0) begin fails++; $display("FAIL alu_no_req: got req=%b stall=%b want 0 0", mem_req, mem_stall); end
    drive_nop();
  endtask

  task automatic test_byte_store();
    drive_nop();
    EX_MEM_LS_bit   = 2'b10;
    EX_MEM_MemWrite = 1'b1;
    EX_MEM_mux5_out = 32'h0000_0103;
    EX_MEM_mux3_out = 32'h0000_00AB;
    EX_MEM_mux1_out = 6'd9;
    #1;
    tests++; if (mem_stall !== 1'b1) begin fails++; $display("FAIL bst_stall_idle: got %b want 1", mem_stall); end
    tick();
    tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1000 || mem_wdata !== 32'hABABABAB) begin
      fails++; $display("FAIL bst_port: got req=%b we=%b addr=%h be=%b wdata=%h want 1 1 00000100 1000 abababab", mem_req, mem_we, mem_addr, mem_be, mem_wdata); end
    tests++; if (MEM_WB_RegWrite !== 1'b0 || MEM_WB_MemtoReg !== 1'b0) begin fails++; $display("FAIL bst_bubble: got rw=%b m2r=%b want 0 0", MEM_WB_RegWrite, MEM_WB_MemtoReg); end
    mem_ready = 1'b1;
    #1;
    tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL bst_stall_done: got %b want 0", mem_stall); end
    tick();
    drive_nop();
    #1;
    tests++; if (mem_req !== 1'b0 || mem_stall !== 1'b0 || MEM_WB_MemtoReg !== 1'b0 || MEM_WB_alu !== 32'h103 || MEM_WB_dst !== 6'd9) begin
      fails++; $display("FAIL bst_retire: got req=%b stall=%b m2r=%b alu=%h dst=%0d want 0 0 0 00000103 9", mem_req, mem_stall, MEM_WB_MemtoReg, MEM_WB_alu, MEM_WB_dst); end
  endtask

  task automatic test_half_store();
    drive_nop();
    EX_MEM_LS_bit   = 2'b01;
    EX_MEM_MemWrite = 1'b1;
    EX_MEM_MemtoReg = 1'b1;   // both set: store wins, no load
    EX_MEM_RegWrite = 1'b1;
    EX_MEM_mux5_out = 32'h0000_0102;
    EX_MEM_mux3_out = 32'h1234_BEEF;
    tick();
    tests++; if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1100 || mem_wdata !== 32'hBEEFBEEF) begin
      fails++; $display("FAIL hst_port: got we=%b addr=%h be=%b wdata=%h want 1 00000100 1100 beefbeef", mem_we, mem_addr, mem_be, mem_wdata); end
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    drive_nop();
    tests++; if (MEM_WB_MemtoReg !== 1'b0 || MEM_WB_load !== 32'h0 || MEM_WB_RegWrite !== 1'b1) begin
      fails++; $display("FAIL hst_suppress_load: got m2r=%b load=%h rw=%b want 0 00000000 1", MEM_WB_MemtoReg, MEM_WB_load, MEM_WB_RegWrite); end
  endtask

  task automatic test_signed_half_load();
    int stalls = 0;
    drive_nop();
    EX_MEM_LS_bit   = 2'b01;
    EX_MEM_MemtoReg = 1'b1;
    EX_MEM_RegWrite = 1'b1;
    EX_MEM_Ext_op   = 1'b1;
    EX_MEM_mux5_out = 32'h0000_0202;
    EX_MEM_mux1_out = 6'd7;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (mem_stall === 1'b1) stalls++;
      tick();
      tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b0000 || mem_addr !== 32'h200 || MEM_WB_RegWrite !== 1'b0 || MEM_WB_MemtoReg !== 1'b0) begin
        fails++; $display("FAIL shl_wait%0d: got req=%b we=%b be=%b addr=%h rw=%b m2r=%b want 1 0 0000 00000200 0 0", c, mem_req, mem_we, mem_be, mem_addr, MEM_WB_RegWrite, MEM_WB_MemtoReg); end
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h8001_7F00;
    #1;
    if (mem_stall === 1'b1) stalls++;
    tests++; if (stalls != 4) begin fails++; $display("FAIL shl_stall_len: got %0d want 4", stalls); end
    tick();
    drive_nop();
    tests++; if (MEM_WB_load !== 32'hFFFF8001 || MEM_WB_MemtoReg !== 1'b1 || MEM_WB_RegWrite !== 1'b1 || MEM_WB_dst !== 6'd7) begin
      fails++; $display("FAIL shl_result: got load=%h m2r=%b rw=%b dst=%0d want ffff8001 1 1 7", MEM_WB_load, MEM_WB_MemtoReg, MEM_WB_RegWrite, MEM_WB_dst); end
  endtask

  task automatic run_load(input logic [1:0] ls, input logic ext, input logic [31:0] addr,
                          input logic [31:0] rdata, output logic [31:0] result);
    drive_nop();
    EX_MEM_LS_bit   = ls;
    EX_MEM_MemtoReg = 1'b1;
    EX_MEM_RegWrite = 1'b1;
    EX_MEM_Ext_op   = ext;
    EX_MEM_mux5_out = addr;
    tick();
    mem_ready = 1'b1;
    mem_rdata = rdata;
    tick();
    drive_nop();
    result = MEM_WB_load;
  endtask

  task automatic test_load_variants();
    logic [31:0] r;
    run_load(2'b10, 1'b0, 32'h201, 32'h0000_F000, r);
    tests++; if (r !== 32'h0000_00F0) begin fails++; $display("FAIL ubyte_load: got %h want 000000f0", r); end
    run_load(2'b10, 1'b1, 32'h203, 32'h9A00_0000, r);
    tests++; if (r !== 32'hFFFF_FF9A) begin fails++; $display("FAIL sbyte_load: got %h want ffffff9a", r); end
    run_load(2'b01, 1'b0, 32'h200, 32'h1234_8765, r);
    tests++; if (r !== 32'h0000_8765) begin fails++; $display("FAIL uhalf_load: got %h want 00008765", r); end
    run_load(2'b11, 1'b1, 32'h300, 32'hCAFE_BABE, r);
    tests++; if (r !== 32'hCAFE_BABE) begin fails++; $display("FAIL word11_load: got %h want cafebabe", r); end
  endtask

  task automatic test_misaligned();
    drive_nop();
    EX_MEM_LS_bit   = 2'b00;
    EX_MEM_MemtoReg = 1'b1;
    EX_MEM_RegWrite = 1'b1;
    EX_MEM_mux5_out = 32'h0000_0302;
    #1;
    tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL mis_stall: got %b want 0", mem_stall); end
    tick();
    drive_nop();
    tests++; if (misalign !== 1'b1 || mem_req !== 1'b0 || MEM_WB_RegWrite !== 1'b0 || MEM_WB_MemtoReg !== 1'b0) begin
      fails++; $display("FAIL mis_trap: got mis=%b req=%b rw=%b m2r=%b want 1 0 0 0", misalign, mem_req, MEM_WB_RegWrite, MEM_WB_MemtoReg); end
    tick();
    tests++; if (misalign !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL mis_pulse: got mis=%b req=%b want 0 0", misalign, mem_req); end
  endtask

  task automatic test_reset_in_busy();
    drive_nop();
    EX_MEM_LS_bit   = 2'b00;
    EX_MEM_MemtoReg = 1'b1;
    EX_MEM_RegWrite = 1'b1;
    EX_MEM_mux5_out = 32'h0000_0400;
    tick();
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rib_busy: got req=%b want 1", mem_req); end
    reset = 1'b1;
    #1;
    tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL rib_stall_in_reset: got %b want 0", mem_stall); end
    tick();
    reset = 1'b0;
    drive_nop();
    EX_MEM_RegWrite = 1'b1;
    EX_MEM_mux5_out = 32'h0000_00AA;
    mem_ready = 1'b1;
    #1;
    tests++; if (mem_req !== 1'b0 || mem_stall !== 1'b0 || {MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_prod, MEM_WB_alu, MEM_WB_load, MEM_WB_dst} !== '0) begin
      fails++; $display("FAIL rib_cleared: got req=%b stall=%b rw=%b alu=%h want 0 0 0 0", mem_req, mem_stall, MEM_WB_RegWrite, MEM_WB_alu); end
    tick();
    tests++; if (MEM_WB_alu !== 32'hAA || MEM_WB_RegWrite !== 1'b1 || mem_req !== 1'b0) begin
      fails++; $display("FAIL rib_idle_pass: got alu=%h rw=%b req=%b want 000000aa 1 0", MEM_WB_alu, MEM_WB_RegWrite, mem_req); end
    drive_nop();
  endtask

  initial begin
    reset = 1'b1;
    drive_nop();
    test_reset();
    test_alu_pass();
    test_byte_store();
    test_half_store();
    test_signed_half_load();
    test_load_variants();
    test_misaligned();
    test_reset_in_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
